chien_search_engine: RTL and testbench

CHIEN_SEARCH_ENGINE -- requirements
Module: chien_search_engine

---
 rtl/rs_gf_pkg.sv | 26 ++
 rtl/full_GF_mult.sv | 27 ++
 rtl/chien_search_engine.sv | 142 ++++++++++++++
 tb/tb_chien_search_engine.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rs_gf_pkg.sv
// rs_gf_pkg: shared GF(2^M) definitions for the Reed-Solomon decoder slice
// (syndrome, Chien search and Forney blocks).
//   M          symbol width in bits
//   N          codeword length in symbols (2^M - 1)
//   PRIM_POLY  field primitive polynomial, x^4 + x + 1
//   ALPHA_POW  alpha^j for j = 0 .. N-1
//   chien_state_t  Chien search controller states
package rs_gf_pkg;

  localparam int M = 4;
  localparam int N = (1 << M) - 1;

  localparam logic [M:0] PRIM_POLY = 5'b10011;

  localparam logic [M-1:0] ALPHA_POW [N] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    FINISH
  } chien_state_t;

endpackage

// File: rtl/full_GF_mult.sv
// full_GF_mult: combinational GF(2^M) multiplier, p = a * b mod POLY.
//   a, b  M-bit field elements
//   p     M-bit product
module full_GF_mult #(
  parameter int         M    = 4,
  parameter logic [M:0] POLY = 5'b10011
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  logic [M-1:0] acc;
  logic [M-1:0] sh;

  // Shift-and-add: sh walks a*x^i, reduced by POLY on every overflow.
  always_comb begin
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY[M-1:0] : '0);
    end
    p = acc;
  end

endmodule

// File: rtl/chien_search_engine.sv
// chien_search_engine: serial Chien search over GF(2^M).
// Evaluates the error locator Lambda(x) at x = alpha^1 .. alpha^N, one point
// per clock, reporting codeword position N-1 down to 0.
//   CLK, RESET_N   clock, asynchronous active-low reset
//   START          one-cycle request, accepted only in IDLE
//   LAMBDA         locator coefficients, lambda_j at LAMBDA[M*j +: M]
//   BUSY           search in progress
//   POS_VALID/POS/ROOT  per-position result stream
//   DONE           one-cycle end-of-search pulse
//   ERR_MASK/ROOT_COUNT/FAIL  final results, held until the next START
module chien_search_engine #(
  parameter int M = rs_gf_pkg::M,
  parameter int N = rs_gf_pkg::N,
  parameter int T = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     START,
  input  logic [(T+1)*M-1:0]       LAMBDA,
  output logic                     BUSY,
  output logic                     POS_VALID,
  output logic [$clog2(N)-1:0]     POS,
  output logic                     ROOT,
  output logic                     DONE,
  output logic [N-1:0]             ERR_MASK,
  output logic [$clog2(N+1)-1:0]   ROOT_COUNT,
  output logic                     FAIL
);

  import rs_gf_pkg::*;

  localparam int POS_W = $clog2(N);
  localparam int CNT_W = $clog2(N+1);
  localparam int DEG_W = $clog2(T+2);

  chien_state_t state_q, state_d;

  logic [M-1:0]     r_q     [T+1];
  logic [M-1:0]     mul_in  [T+1];
  logic [M-1:0]     mul_out [T+1];
  logic [M-1:0]     sum_c;
  logic [POS_W-1:0] cnt_q;
  logic [DEG_W-1:0] deg_q, deg_c;
  logic             l0_zero_q;
  logic             accept;
  logic             searching;
  logic [CNT_W-1:0] count_final;

  assign accept    = (state_q == IDLE) && START;
  assign searching = (state_q == SEARCH);

  // One multiplier per cell serves both paths: in IDLE it scales the incoming
  // lambda_j by alpha^j, in SEARCH it advances r_j by alpha^j.
  for (genvar j = 0; j <= T; j++) begin : g_cell
    assign mul_in[j] = (state_q == IDLE) ? LAMBDA[M*j +: M] : r_q[j];

    full_GF_mult #(
      .M    (M),
      .POLY (PRIM_POLY)
    ) u_mult (
      .a (mul_in[j]),
      .b (ALPHA_POW[j % N]),
      .p (mul_out[j])
    );
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned j = 0; j < T + 1; j++) sum_c = sum_c ^ r_q[j];
  end

  always_comb begin
    deg_c = '0;
    for (int unsigned j = 0; j < T + 1; j++) begin
      if (LAMBDA[M*j +: M] != '0) deg_c = DEG_W'(j);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    BUSY      = 1'b0;
    POS_VALID = 1'b0;
    POS       = '0;
    ROOT      = 1'b0;
    DONE      = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) state_d = SEARCH;
      end
      SEARCH: begin
        BUSY      = 1'b1;
        POS_VALID = 1'b1;
        POS       = cnt_q;
        ROOT      = (sum_c == '0);
        if (cnt_q == '0) state_d = FINISH;
      end
      FINISH: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Count including the root found on the last step, so FAIL is already
  // valid in the DONE cycle.
  assign count_final = ROOT_COUNT + CNT_W'(ROOT);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned j = 0; j < T + 1; j++) r_q[j] <= '0;
      cnt_q      <= '0;
      deg_q      <= '0;
      l0_zero_q  <= 1'b0;
      ERR_MASK   <= '0;
      ROOT_COUNT <= '0;
      FAIL       <= 1'b0;
    end else if (accept) begin
      for (int unsigned j = 0; j < T + 1; j++) r_q[j] <= mul_out[j];
      cnt_q      <= POS_W'(N - 1);
      deg_q      <= deg_c;
      l0_zero_q  <= (LAMBDA[M-1:0] == '0);
      ERR_MASK   <= '0;
      ROOT_COUNT <= '0;
      FAIL       <= 1'b0;
    end else if (searching) begin
      for (int unsigned j = 0; j < T + 1; j++) r_q[j] <= mul_out[j];
      if (ROOT) begin
        ERR_MASK[cnt_q] <= 1'b1;
        ROOT_COUNT      <= ROOT_COUNT + 1'b1;
      end
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      else             FAIL  <= (count_final != CNT_W'(deg_q)) || l0_zero_q;
    end
  end

endmodule

// File: tb/tb_chien_search_engine.sv
// tb_chien_search_engine: directed self-checking bench for chien_search_engine
// (M=4, N=15, T=2) with hand-computed root positions and results.
module tb_chien_search_engine;

  localparam int M = 4;
  localparam int N = 15;
  localparam int T = 2;

  logic                 CLK = 1'b0;
  logic                 RESET_N;
  logic                 START;
  logic [(T+1)*M-1:0]   LAMBDA;
  logic                 BUSY;
  logic                 POS_VALID;
  logic [3:0]           POS;
  logic                 ROOT;
  logic                 DONE;
  logic [N-1:0]         ERR_MASK;
  logic [3:0]           ROOT_COUNT;
  logic                 FAIL;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  chien_search_engine #(
    .M (M),
    .N (N),
    .T (T)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .LAMBDA     (LAMBDA),
    .BUSY       (BUSY),
    .POS_VALID  (POS_VALID),
    .POS        (POS),
    .ROOT       (ROOT),
    .DONE       (DONE),
    .ERR_MASK   (ERR_MASK),
    .ROOT_COUNT (ROOT_COUNT),
    .FAIL       (FAIL)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expd);
    n_checks++;
    if (act !== expd) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expd);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, " busy"},      32'(BUSY),      32'd0);
    check_eq({tag, " pos_valid"}, 32'(POS_VALID), 32'd0);
    check_eq({tag, " pos"},       32'(POS),       32'd0);
    check_eq({tag, " root"},      32'(ROOT),      32'd0);
    check_eq({tag, " done"},      32'(DONE),      32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the first negedge where
  // the DUT is idle again, so searches can be issued back to back.
  task automatic run_search(input string name, input logic [11:0] lam,
                            input logic [14:0] exp_mask, input int exp_cnt,
                            input logic exp_fail, input int repulse_c,
                            input logic [11:0] repulse_lam);
    START  = 1'b1;
    LAMBDA = lam;
    @(negedge CLK);
    START  = 1'b0;
    LAMBDA = ~lam;
    for (int c = 1; c <= N; c++) begin
      if (c == repulse_c) begin
        START  = 1'b1;
        LAMBDA = repulse_lam;
      end else begin
        START  = 1'b0;
      end
      check_eq($sformatf("%s pos_valid c%0d", name, c), 32'(POS_VALID), 32'd1);
      check_eq($sformatf("%s busy c%0d", name, c),      32'(BUSY),      32'd1);
      check_eq($sformatf("%s done c%0d", name, c),      32'(DONE),      32'd0);
      check_eq($sformatf("%s pos c%0d", name, c),       32'(POS),       32'(N - c));
      check_eq($sformatf("%s root c%0d", name, c),      32'(ROOT),      32'(exp_mask[N - c]));
      @(negedge CLK);
    end
    START = 1'b0;
    check_eq({name, " done pulse"}, 32'(DONE),       32'd1);
    check_eq({name, " busy@done"},  32'(BUSY),       32'd0);
    check_eq({name, " pv@done"},    32'(POS_VALID),  32'd0);
    check_eq({name, " root@done"},  32'(ROOT),       32'd0);
    check_eq({name, " mask"},       32'(ERR_MASK),   32'(exp_mask));
    check_eq({name, " count"},      32'(ROOT_COUNT), 32'(exp_cnt));
    check_eq({name, " fail"},       32'(FAIL),       32'(exp_fail));
    @(negedge CLK);
    check_quiet({name, " after"});
    check_eq({name, " mask held"},  32'(ERR_MASK),   32'(exp_mask));
    check_eq({name, " count held"}, 32'(ROOT_COUNT), 32'(exp_cnt));
    check_eq({name, " fail held"},  32'(FAIL),       32'(exp_fail));
  endtask

  initial begin
    RESET_N = 1'b0;
    START   = 1'b0;
    LAMBDA  = '0;
    #1;
    check_quiet("reset");
    check_eq("reset mask",  32'(ERR_MASK),   32'd0);
    check_eq("reset count", 32'(ROOT_COUNT), 32'd0);
    check_eq("reset fail",  32'(FAIL),       32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check_quiet("idle");

    // Errors at 3 and 7: Lambda = 1 + 3x + 7x^2
    run_search("e37",  12'h731, 15'h0088,  2, 1'b0, 0, 12'h000);
    // Lambda = 1 + x: root only at x = 1 (position 0, last step)
    run_search("e0",   12'h011, 15'h0001,  1, 1'b0, 0, 12'h000);
    run_search("none", 12'h001, 15'h0000,  0, 1'b0, 0, 12'h000);
    run_search("zero", 12'h000, 15'h7FFF, 15, 1'b1, 0, 12'h000);
    run_search("l0z",  12'h100, 15'h0000,  0, 1'b1, 0, 12'h000);
    // Lambda = (1 + x)^2: a single distinct root, degree 2
    run_search("dbl",  12'h101, 15'h0001,  1, 1'b1, 0, 12'h000);
    // START re-pulsed mid-search with another locator must be ignored
    run_search("rep",  12'h731, 15'h0088,  2, 1'b0, 5, 12'h011);

    // Reset in the middle of a search
    START  = 1'b1;
    LAMBDA = 12'h731;
    @(negedge CLK);
    START  = 1'b0;
    repeat (7) @(negedge CLK);
    check_eq("pre-rst pv",  32'(POS_VALID), 32'd1);
    check_eq("pre-rst pos", 32'(POS),       32'd7);
    RESET_N = 1'b0;
    #1;
    check_quiet("midrst");
    check_eq("midrst mask",  32'(ERR_MASK),   32'd0);
    check_eq("midrst count", 32'(ROOT_COUNT), 32'd0);
    check_eq("midrst fail",  32'(FAIL),       32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check_eq($sformatf("in-rst done %0d", c), 32'(DONE), 32'd0);
      check_eq($sformatf("in-rst busy %0d", c), 32'(BUSY), 32'd0);
    end
    RESET_N = 1'b1;
    @(negedge CLK);
    check_quiet("post-rst idle");
    run_search("post", 12'h731, 15'h0088,  2, 1'b0, 0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
